// File: rtl/usb_tx_pkg.sv
// Shared types and widths for the USB transmit path.
package usb_tx_pkg;

    localparam int unsigned PKT_BUF_W = 100;
    localparam int unsigned CRC5_W    = 5;
    localparam int unsigned CRC16_W   = 16;
    localparam int unsigned LEN_W     = 32;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StGap
    } sched_state_t;

    function automatic logic [1:0] src_onehot(input logic src);
        return src ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/crc_tx_sched_if.sv
// Handshake bundle between the packet sources, the scheduler and the CRC datapath.
interface crc_tx_sched_if;
    import usb_tx_pkg::*;

    logic [1:0]           req;
    logic [PKT_BUF_W-1:0] pkt0;
    logic [PKT_BUF_W-1:0] pkt1;
    logic [LEN_W-1:0]     len0;
    logic [LEN_W-1:0]     len1;
    logic [1:0]           gnt;
    logic [1:0]           done;
    logic [1:0]           err;
    logic                 busy;
    logic [PKT_BUF_W-1:0] pkt_in;
    logic [LEN_W-1:0]     pkt_len;
    logic                 pkt_ready;
    logic                 crc_sending;
    logic                 bs_ready;

    modport master (
        output req, pkt0, pkt1, len0, len1, crc_sending, bs_ready,
        input  gnt, done, err, busy, pkt_in, pkt_len, pkt_ready
    );

    modport slave (
        input  req, pkt0, pkt1, len0, len1, crc_sending, bs_ready,
        output gnt, done, err, busy, pkt_in, pkt_len, pkt_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-winner pointer.
module rr_arb2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o,
    output logic       win_o,
    output logic       last_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        win_o = 1'b0;
        case (req_i)
            2'b01: begin
                gnt_o = 2'b01;
                win_o = 1'b0;
            end
            2'b10: begin
                gnt_o = 2'b10;
                win_o = 1'b1;
            end
            2'b11: begin
                // On a tie the source that did not win last time goes first.
                win_o = ~last_q;
                gnt_o = last_q ? 2'b01 : 2'b10;
            end
            default: ;
        endcase
        last_d = (upd_i && (req_i != 2'b00)) ? win_o : last_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/crc_tx_sched.sv
// Shares the serial CRC-append datapath between two packet sources: arbitration,
// packet latch, bit counting with watchdog, and an inter-packet gap.
module crc_tx_sched
    import usb_tx_pkg::*;
#(
    parameter int unsigned CRC_W   = CRC5_W,
    parameter int unsigned IPG     = 2,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned MIN_LEN = 9,
    parameter int unsigned MAX_LEN = PKT_BUF_W
) (
    input logic           clock,
    input logic           reset_n,
    crc_tx_sched_if.slave bus
);

    localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
    localparam int unsigned GapW = (IPG > 1) ? $clog2(IPG) : 1;

    sched_state_t         state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [1:0]           done_q, done_d;
    logic [1:0]           err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 pkt_ready_q, pkt_ready_d;
    logic [PKT_BUF_W-1:0] pkt_in_q, pkt_in_d;
    logic [LEN_W-1:0]     pkt_len_q, pkt_len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [WdW-1:0]       wd_q, wd_d;
    logic [GapW-1:0]      gap_q, gap_d;

    logic [1:0]       arb_gnt;
    logic             arb_win;
    logic             arb_last;
    logic             arb_upd;
    logic [LEN_W-1:0] win_len;
    logic             len_ok;
    logic [LEN_W-1:0] send_target;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset_n(reset_n),
        .req_i  (bus.req),
        .upd_i  (arb_upd),
        .gnt_o  (arb_gnt),
        .win_o  (arb_win),
        .last_o (arb_last)
    );

    assign win_len     = arb_win ? bus.len1 : bus.len0;
    assign len_ok      = (win_len >= LEN_W'(MIN_LEN)) && (win_len <= LEN_W'(MAX_LEN));
    assign send_target = pkt_len_q + LEN_W'(CRC_W);

    always_comb begin
        state_d     = state_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        err_d       = 2'b00;
        pkt_ready_d = 1'b0;
        pkt_in_d    = pkt_in_q;
        pkt_len_d   = pkt_len_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        arb_upd     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req != 2'b00) begin
                    arb_upd = 1'b1;
                    if (!len_ok) begin
                        err_d = arb_gnt;
                    end else begin
                        gnt_d     = arb_gnt;
                        pkt_in_d  = arb_win ? bus.pkt1 : bus.pkt0;
                        pkt_len_d = win_len;
                        state_d   = StLoad;
                    end
                end
            end
            StLoad: begin
                pkt_ready_d = 1'b1;
                cnt_d       = '0;
                wd_d        = '0;
                state_d     = StSend;
            end
            StSend: begin
                // A stalled cycle with a valid bit still proves the datapath is alive.
                if (bus.crc_sending) begin
                    wd_d = '0;
                end else if (bus.bs_ready) begin
                    wd_d = wd_q + 1'b1;
                end
                if (bus.crc_sending && bus.bs_ready) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // The owner of the packet in flight is always the last arbiter winner.
                if (cnt_d == send_target) begin
                    done_d  = src_onehot(arb_last);
                    gap_d   = '0;
                    state_d = StGap;
                end else if (wd_d == WdW'(TIMEOUT)) begin
                    err_d   = src_onehot(arb_last);
                    gap_d   = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == GapW'(IPG - 1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            pkt_ready_q <= 1'b0;
            pkt_in_q    <= '0;
            pkt_len_q   <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            pkt_ready_q <= pkt_ready_d;
            pkt_in_q    <= pkt_in_d;
            pkt_len_q   <= pkt_len_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.pkt_ready = pkt_ready_q;
    assign bus.pkt_in    = pkt_in_q;
    assign bus.pkt_len   = pkt_len_q;

endmodule

// File: tb/tb_crc_tx_sched.sv
// Scoreboard bench for crc_tx_sched with a behavioural CRC datapath / bit-stuffer model.
module tb_crc_tx_sched;
    import usb_tx_pkg::*;

    localparam int KGnt  = 0;
    localparam int KErr  = 1;
    localparam int KRdy  = 2;
    localparam int KDone = 3;

    localparam logic [PKT_BUF_W-1:0] P0 = {81'd0, 19'b0100_0000101_11100001};
    localparam logic [PKT_BUF_W-1:0] P1 = {70'd0, 30'h2A5C3E1D};

    typedef struct {
        int                   kind;
        logic [1:0]           vec;
        int                   gap;
        logic [PKT_BUF_W-1:0] pin;
        logic [LEN_W-1:0]     plen;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    exp_t sb[$];

    int   dp_rem = 0;
    int   dp_emit = 0;
    bit   dp_mute = 1'b0;
    bit   dp_stall_en = 1'b0;
    bit   stall_done[3];
    int   stall_pts[3] = '{5, 12, 21};

    crc_tx_sched_if bus ();

    crc_tx_sched #(
        .CRC_W  (5),
        .IPG    (2),
        .TIMEOUT(64),
        .MIN_LEN(9),
        .MAX_LEN(100)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    function automatic string kname(input int k);
        case (k)
            KGnt:    return "gnt";
            KErr:    return "err";
            KRdy:    return "pkt_ready";
            default: return "done";
        endcase
    endfunction

    task automatic push(input int kind, input logic [1:0] vec, input int gap,
                        input logic [PKT_BUF_W-1:0] pin, input logic [LEN_W-1:0] plen);
        exp_t e;
        e.kind = kind;
        e.vec  = vec;
        e.gap  = gap;
        e.pin  = pin;
        e.plen = plen;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [1:0] vec);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s got %b required no event (cycle %0d)", kname(kind), vec,
                     cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.vec != vec) begin
                errors++;
                $display("FAIL event_order got %s=%b required %s=%b (cycle %0d)", kname(kind), vec,
                         kname(e.kind), e.vec, cyc);
            end else if (e.gap >= 0 && (cyc - last_cyc) != e.gap) begin
                errors++;
                $display("FAIL %s_latency got %0d cycles required %0d", kname(kind),
                         cyc - last_cyc, e.gap);
            end else if (kind == KRdy && (bus.pkt_in != e.pin || bus.pkt_len != e.plen)) begin
                errors++;
                $display("FAIL pkt_latch got len %0d data %h required len %0d data %h",
                         bus.pkt_len, bus.pkt_in, e.plen, e.pin);
            end
        end
        last_cyc = cyc;
    endtask

    // Monitor: samples on the falling edge, pops and compares every output event.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                if (bus.gnt != 2'b00)  check_ev(KGnt, bus.gnt);
                if (bus.err != 2'b00)  check_ev(KErr, bus.err);
                if (bus.pkt_ready)     check_ev(KRdy, 2'b00);
                if (bus.done != 2'b00) check_ev(KDone, bus.done);
            end
        end
    end

    // Datapath model: after pkt_ready, emits pkt_len+5 bits, one per bs_ready cycle.
    initial begin
        bit consumed;
        bus.crc_sending = 1'b0;
        bus.bs_ready    = 1'b1;
        forever begin
            @(posedge clock);
            consumed = bus.crc_sending && bus.bs_ready;
            #1;
            if (!reset_n) begin
                dp_rem  = 0;
                dp_emit = 0;
            end else begin
                if (consumed && dp_rem > 0) begin
                    dp_rem--;
                    dp_emit++;
                end
                if (bus.pkt_ready && !dp_mute) begin
                    dp_rem  = int'(bus.pkt_len) + 5;
                    dp_emit = 0;
                end
            end
            bus.crc_sending = (dp_rem > 0);
            bus.bs_ready    = 1'b1;
            if (dp_stall_en && dp_rem > 0) begin
                for (int k = 0; k < 3; k++) begin
                    if (!stall_done[k] && dp_emit == stall_pts[k]) begin
                        bus.bs_ready  = 1'b0;
                        stall_done[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_out(input int kind, input string what, output logic [1:0] seen);
        bit hit = 1'b0;
        seen = 2'b00;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clock);
            #1;
            case (kind)
                KGnt:    seen = bus.gnt;
                KErr:    seen = bus.err;
                default: seen = bus.done;
            endcase
            hit = (seen != 2'b00);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got no %s required one within 300 cycles", what, kname(kind));
        end
    endtask

    task automatic check_val(input string what, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", what, got, req);
        end
    endtask

    task automatic run_one(input logic [1:0] src, input string what);
        logic [1:0] seen;
        bus.req = src;
        wait_out(KGnt, what, seen);
        bus.req = 2'b00;
        check_val({what, "_busy"}, 128'(bus.busy), 128'(1'b1));
        wait_out(KDone, what, seen);
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [1:0] seen;
        bus.req  = 2'b00;
        bus.pkt0 = P0;
        bus.pkt1 = P1;
        bus.len0 = 32'd19;
        bus.len1 = 32'd30;

        repeat (3) @(posedge clock);
        #1;
        check_val("reset_ctrl", 128'({bus.busy, bus.pkt_ready, bus.gnt, bus.done, bus.err}),
                  128'(0));
        check_val("reset_pkt_in", 128'(bus.pkt_in), 128'(0));
        check_val("reset_pkt_len", 128'(bus.pkt_len), 128'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Single packet: 19 body bits + 5 CRC bits.
        push(KGnt, 2'b01, -1, '0, '0);
        push(KRdy, 2'b00, 1, P0, 32'd19);
        push(KDone, 2'b01, 24, '0, '0);
        run_one(2'b01, "single");

        // Three one-cycle stalls push done out by three cycles.
        stall_done  = '{1'b0, 1'b0, 1'b0};
        dp_stall_en = 1'b1;
        push(KGnt, 2'b01, -1, '0, '0);
        push(KRdy, 2'b00, 1, P0, 32'd19);
        push(KDone, 2'b01, 27, '0, '0);
        run_one(2'b01, "stall");
        dp_stall_en = 1'b0;

        // Illegal lengths on source 1.
        for (int i = 0; i < 2; i++) begin
            bus.len1 = (i == 0) ? 32'd8 : 32'd101;
            push(KErr, 2'b10, -1, '0, '0);
            bus.req = 2'b10;
            wait_out(KErr, "badlen", seen);
            bus.req = 2'b00;
            check_val("badlen_busy", 128'(bus.busy), 128'(1'b0));
            check_val("badlen_pkt_in", 128'(bus.pkt_in), 128'(P0));
            repeat (3) @(posedge clock);
            #1;
        end
        bus.len1 = 32'd30;

        // Contention: grants alternate 0,1,0,1 with IPG+1 spacing after each done.
        for (int i = 0; i < 4; i++) begin
            push(KGnt, (i % 2 == 0) ? 2'b01 : 2'b10, (i == 0) ? -1 : 3, '0, '0);
            push(KRdy, 2'b00, 1, (i % 2 == 0) ? P0 : P1, (i % 2 == 0) ? 32'd19 : 32'd30);
            push(KDone, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 24 : 35, '0, '0);
        end
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] g;
            wait_out(KGnt, "contend", g);
            bus.req = bus.req & ~g;
            wait_out(KDone, "contend", seen);
            if (i < 2) bus.req = bus.req | g;
        end
        repeat (4) @(posedge clock);
        #1;

        // Watchdog: silent datapath aborts after 64 ready cycles, then a clean packet.
        dp_mute = 1'b1;
        push(KGnt, 2'b01, -1, '0, '0);
        push(KRdy, 2'b00, 1, P0, 32'd19);
        push(KErr, 2'b01, 64, '0, '0);
        push(KGnt, 2'b10, 3, '0, '0);
        push(KRdy, 2'b00, 1, P1, 32'd30);
        push(KDone, 2'b10, 35, '0, '0);
        bus.req = 2'b01;
        wait_out(KGnt, "wdog", seen);
        bus.req = 2'b00;
        wait_out(KErr, "wdog", seen);
        dp_mute = 1'b0;
        run_one(2'b10, "after_wdog");

        // Reset while sending bit 10, then a fresh request from source 1.
        push(KGnt, 2'b10, -1, '0, '0);
        push(KRdy, 2'b00, 1, P1, 32'd30);
        bus.req = 2'b10;
        wait_out(KGnt, "midrst", seen);
        bus.req = 2'b00;
        for (int i = 0; i < 100 && dp_emit != 10; i++) begin
            @(posedge clock);
            #2;
        end
        check_val("midrst_bitcount", 128'(dp_emit), 128'(10));
        reset_n = 1'b0;
        #1;
        check_val("midrst_ctrl", 128'({bus.busy, bus.pkt_ready, bus.gnt, bus.done, bus.err}),
                  128'(0));
        check_val("midrst_pkt", 128'({bus.pkt_in, bus.pkt_len}), 128'(0));
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        push(KGnt, 2'b10, -1, '0, '0);
        push(KRdy, 2'b00, 1, P1, 32'd30);
        push(KDone, 2'b10, 35, '0, '0);
        run_one(2'b10, "postrst");

        repeat (5) @(posedge clock);
        #1;
        check_val("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no completion required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/crc_tx_sched.md
# crc_tx_sched

Transmit scheduler that shares the single serial CRC-append datapath (`CRC_Calc`) between two packet sources: a token/handshake source (requester 0) and a data source (requester 1). It does three things:
- arbitrates round-robin between the sources;
- latches the winner's packet and length, pulses `pkt_ready` into the datapath, and counts the bits the datapath emits;
- reports completion, then enforces an inter-packet gap before the next grant.

It sits between the protocol handler and `CRC_Calc`/bit-stuffer.

## Interface
Parameters:
- `CRC_W`, 5: CRC bits appended after the packet body.
- `IPG`, 2: idle cycles between packets, ≥1.
- `TIMEOUT`, 64: maximum consecutive SEND cycles with `bs_ready`=1 and `crc_sending`=0.
- `MIN_LEN`, 9: smallest legal `lenN` (PID plus one bit).
- `MAX_LEN`, 100: largest legal `lenN` (datapath buffer width).

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-source request level; held until `gnt` for that source.
- `pkt0`, `pkt1` in 100 each: packet bits, LSB first; sampled on grant.
- `len0`, `len1` in 32 each: packet length in bits, including the 8-bit PID.
- `gnt` out 2: one-hot, 1-cycle pulse; request accepted.
- `done` out 2: one-hot, 1-cycle pulse; packet fully emitted.
- `err` out 2: one-hot, 1-cycle pulse; length rejected or watchdog abort.
- `busy` out 1: high in every state except IDLE.
- `pkt_in` out 100: latched packet to the datapath.
- `pkt_len` out 32: latched length to the datapath.
- `pkt_ready` out 1: 1-cycle load pulse to the datapath.
- `crc_sending` in 1: datapath is emitting a valid bit this cycle.
- `bs_ready` in 1: bit-stuffer accepts a bit this cycle.

## Operation
- FSM states: IDLE, LOAD, SEND, GAP.
- Reset values: state=IDLE; all outputs 0, including `pkt_in` and `pkt_len`; bit counter 0; gap counter 0; watchdog 0; round-robin pointer `last`=1, so source 0 wins the first tie.

IDLE, when `req`≠0:
- Winner: the single requester, or on `req`=2'b11 the source ≠ `last`.
- `gnt[w]` pulses; `pkt_in`/`pkt_len` latch `pktw`/`lenw`; `last`←w.
- Length check: if `lenw`<MIN_LEN or `lenw`>MAX_LEN, `err[w]` pulses in the same cycle instead of `gnt[w]`. `last` still updates. The FSM stays in IDLE and `pkt_in` is not updated.
- Legal length: next state LOAD.

LOAD:
- `pkt_ready`=1 for exactly this cycle.
- Bit counter←0; next state SEND.

SEND:
- Each cycle with `crc_sending`=1 increments the counter.
- When the counter reaches `pkt_len`+CRC_W (32-bit compare, no wrap possible given MAX_LEN): `done[w]` pulses on the next cycle and the FSM enters GAP.
- Watchdog increments on cycles with `bs_ready`=1 and `crc_sending`=0, and clears on any `crc_sending`=1 cycle.
- If the watchdog reaches TIMEOUT: `err[w]` pulses, the FSM enters GAP, and no `done` is issued.
- Cycles with `bs_ready`=0 are stalls: they neither count bits nor advance the watchdog.

GAP:
- Counts IPG cycles, then returns to IDLE.
- `req` is ignored throughout GAP.

`pkt_in`/`pkt_len` hold stable from LOAD until the next grant.

## Timing
- Grant latency: `req` rising at edge N, FSM in IDLE → `gnt` during cycle N, `pkt_ready` during cycle N+1.
- Back-to-back packets: minimum spacing between `done` and the next `gnt` is IPG+1 cycles.
- `done`/`err` are registered; never both in the same cycle.
- `req` dropped after grant has no effect on the packet in flight.
- Reset asserted mid-packet: everything returns to reset values immediately and no `done` is issued. The datapath is reset by the same `reset_n`.

## Structure
- Shared package `usb_tx_pkg`: state enum `sched_state_t`, `PKT_BUF_W`=100, `CRC5_W`=5, `CRC16_W`=16.
- One natural sub-module: `rr_arb2` (2-way round-robin with `last` pointer, combinational grant plus pointer register).
- Datapath muxing and counters stay in `crc_tx_sched`.

## Test plan
- Single packet: `req`=01, `len0`=19, `pkt0`=19'b0100_0000101_11100001, `bs_ready`=1, datapath model emitting continuously → `gnt`=01, `pkt_ready` one cycle later, `done`=01 after 24 `crc_sending` cycles.
- Contention: `req`=11 from reset → source 0 granted first; after source 0's `done` and IPG=2 idle cycles, source 1 granted; repeat → grants alternate 0,1,0,1.
- Stalls: `bs_ready` low for 1 cycle twice mid-body and once during CRC flush → `done` delayed 3 cycles; counter still ends at 24; no `err`.
- Illegal length: `len1`=8, then `len1`=101 → `err`=10 pulse each time, no `pkt_ready`, `busy` stays 0, `pkt_in` unchanged.
- Watchdog: model never raises `crc_sending`, `bs_ready`=1 → `err`=01 after 64 SEND cycles, no `done`; a subsequent legal request is granted after IPG.
- Reset mid-SEND at bit 10 → all outputs 0 within the reset assertion, state IDLE; a fresh `req`=10 after release is granted normally.
